// File: rtl/hd44780_ctrl.sv
// 4-bit HD44780 LCD bus sequencer: a valid/ready byte interface driven out as E-strobed nibbles.
// Define HD44780_INIT_EN to run the power-on initialisation sequence in hardware.
module hd44780_ctrl #(
   parameter int CNT_W       = 20,
   parameter int T_SETUP     = 1,
   parameter int T_EPULSE    = 6,
   parameter int T_HOLD      = 1,
   parameter int T_EXEC      = 480,
   parameter int T_CLEAR     = 19680,
   parameter int T_POWERUP   = 480000,
   parameter int T_INIT_LONG = 49200
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic       wr_rs,
   input  logic       wr_nib,
   input  logic [7:0] wr_data,
   output logic       init_done,
   output logic       busy,
   output logic       lcd_rs,
   output logic       lcd_e,
   output logic [3:0] lcd_d
);

   typedef enum logic [2:0] {
      S_PWRUP, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
`ifdef HD44780_INIT_EN
      , S_INIT
`endif
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_rs;
   logic             r_nib;
   logic [7:0]       r_data;
   logic             r_lo;
   logic             r_long;
   logic             r_ready;
   logic             r_busy;
   logic             r_init_done;
   logic             r_lcd_e;
   logic             r_lcd_rs;
   logic [3:0]       r_lcd_d;
`ifdef HD44780_INIT_EN
   logic [2:0]       r_istep;
   logic [7:0]       w_init_byte;
`endif

   logic [CNT_W-1:0] w_lim;
   logic [CNT_W-1:0] w_wlim;
   logic             w_clr;
   logic             w_done;

   // Clear (0x01) and home (0x02/0x03) instructions need the long execution wait
   assign w_clr  = ~r_rs && (r_data == 8'h01 || r_data == 8'h02 || r_data == 8'h03);
   assign w_wlim = r_long ? CNT_W'(T_INIT_LONG - 1) :
                   w_clr  ? CNT_W'(T_CLEAR - 1)     : CNT_W'(T_EXEC - 1);

   always_comb begin
      w_lim = '0;
      case (r_state)
         S_PWRUP: w_lim = CNT_W'(T_POWERUP - 1);
         S_SETUP: w_lim = CNT_W'(T_SETUP - 1);
         S_PULSE: w_lim = CNT_W'(T_EPULSE - 1);
         S_HOLD:  w_lim = CNT_W'(T_HOLD - 1);
         S_WAIT:  w_lim = w_wlim;
         default: w_lim = '0;
      endcase
   end
   assign w_done = (r_cnt == w_lim);

`ifdef HD44780_INIT_EN
   always_comb begin
      w_init_byte = 8'h30;
      case (r_istep)
         3'd3:    w_init_byte = 8'h20;
         3'd4:    w_init_byte = 8'h28;
         3'd5:    w_init_byte = 8'h0C;
         3'd6:    w_init_byte = 8'h01;
         3'd7:    w_init_byte = 8'h06;
         default: w_init_byte = 8'h30;
      endcase
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_PWRUP;
         r_cnt       <= '0;
         r_rs        <= 1'b0;
         r_nib       <= 1'b0;
         r_data      <= 8'h00;
         r_lo        <= 1'b0;
         r_long      <= 1'b0;
         r_ready     <= 1'b0;
         r_busy      <= 1'b1;
         r_init_done <= 1'b0;
         r_lcd_e     <= 1'b0;
         r_lcd_rs    <= 1'b0;
         r_lcd_d     <= 4'h0;
`ifdef HD44780_INIT_EN
         r_istep     <= 3'd0;
`endif
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
         case (r_state)
            S_PWRUP: if (w_done) begin
               r_cnt <= '0;
`ifdef HD44780_INIT_EN
               r_state <= S_INIT;
               r_istep <= 3'd0;
`else
               r_state     <= S_IDLE;
               r_init_done <= 1'b1;
               r_ready     <= 1'b1;
               r_busy      <= 1'b0;
`endif
            end
`ifdef HD44780_INIT_EN
            S_INIT: begin
               r_cnt    <= '0;
               r_rs     <= 1'b0;
               r_nib    <= (r_istep < 3'd4);
               r_long   <= (r_istep < 3'd2);
               r_data   <= w_init_byte;
               r_lo     <= 1'b0;
               r_lcd_rs <= 1'b0;
               r_lcd_d  <= w_init_byte[7:4];
               r_state  <= S_SETUP;
            end
`endif
            S_IDLE: begin
               r_cnt <= '0;
               if (wr_valid && r_ready) begin
                  r_rs     <= wr_rs;
                  r_nib    <= wr_nib;
                  r_data   <= wr_data;
                  r_long   <= 1'b0;
                  r_lo     <= 1'b0;
                  r_lcd_rs <= wr_rs;
                  r_lcd_d  <= wr_data[7:4];
                  r_ready  <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= S_SETUP;
               end
            end
            S_SETUP: if (w_done) begin
               r_cnt   <= '0;
               r_lcd_e <= 1'b1;
               r_state <= S_PULSE;
            end
            S_PULSE: if (w_done) begin
               r_cnt   <= '0;
               r_lcd_e <= 1'b0;
               r_state <= S_HOLD;
            end
            S_HOLD: if (w_done) begin
               r_cnt <= '0;
               if (!r_nib && !r_lo) begin
                  r_lo    <= 1'b1;
                  r_lcd_d <= r_data[3:0];
                  r_state <= S_SETUP;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: if (w_done) begin
               r_cnt       <= '0;
               r_state     <= S_IDLE;
               r_ready     <= 1'b1;
               r_busy      <= 1'b0;
               r_init_done <= 1'b1;
`ifdef HD44780_INIT_EN
               // Until the last init step is done, loop back for the next one
               if (!r_init_done && r_istep != 3'd7) begin
                  r_state     <= S_INIT;
                  r_ready     <= 1'b0;
                  r_busy      <= 1'b1;
                  r_init_done <= 1'b0;
                  r_istep     <= r_istep + 3'd1;
               end
`endif
            end
            default: begin
               r_cnt   <= '0;
               r_state <= S_PWRUP;
            end
         endcase
      end
   end

   assign wr_ready  = r_ready;
   assign busy      = r_busy;
   assign init_done = r_init_done;
   assign lcd_e     = r_lcd_e;
   assign lcd_rs    = r_lcd_rs;
   assign lcd_d     = r_lcd_d;

endmodule

// File: tb/tb_hd44780_ctrl.sv
// Self-checking bench for hd44780_ctrl: directed and randomized writes against a
// behavioural model of nibble order, E width and ready latency.
module tb_hd44780_ctrl;

   localparam int TS = 1, TE = 2, TH = 1, TX = 8, TC = 20, TP = 50, TL = 30;
   localparam int PH = TS + TE + TH;

   logic       clk, rst;
   logic       wr_valid, wr_ready, wr_rs, wr_nib;
   logic [7:0] wr_data;
   logic       init_done, busy, lcd_rs, lcd_e;
   logic [3:0] lcd_d;

   int n_err = 0;
   int n_chk = 0;

   hd44780_ctrl #(
      .CNT_W(20), .T_SETUP(TS), .T_EPULSE(TE), .T_HOLD(TH), .T_EXEC(TX),
      .T_CLEAR(TC), .T_POWERUP(TP), .T_INIT_LONG(TL)
   ) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_rs(wr_rs), .wr_nib(wr_nib), .wr_data(wr_data), .init_done(init_done),
      .busy(busy), .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_d(lcd_d)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // E-strobe monitor: nibble/rs at each rise, high width and rise/fall cycle stamps
   int   cyc = 0;
   int   hi_w = 0;
   logic e_prev = 1'b0;
   int   q_d[$], q_rs[$], q_w[$], q_rise[$], q_fall[$];

   always @(negedge clk) begin
      cyc++;
      if (lcd_e === 1'b1 && e_prev !== 1'b1) begin
         q_d.push_back(int'(lcd_d));
         q_rs.push_back(int'(lcd_rs));
         q_rise.push_back(cyc);
         hi_w = 0;
      end
      if (lcd_e === 1'b1) hi_w++;
      if (lcd_e !== 1'b1 && e_prev === 1'b1) begin
         q_w.push_back(hi_w);
         q_fall.push_back(cyc);
      end
      e_prev = lcd_e;
   end

   task automatic clear_q();
      q_d.delete(); q_rs.delete(); q_w.delete(); q_rise.delete(); q_fall.delete();
   endtask

   // Wait for ready, issue one transfer, return edges from acceptance to ready-again
   task automatic do_write(input logic rs, input logic nib, input logic [7:0] d,
                           output int lat, output logic drop_ok);
      int w;
      w = 0;
      while (wr_ready !== 1'b1 && w < 5000) begin @(posedge clk); #1; w++; end
      clear_q();
      wr_rs = rs; wr_nib = nib; wr_data = d; wr_valid = 1'b1;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      drop_ok = (wr_ready === 1'b0) && (busy === 1'b1);
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (wr_ready !== 1'b1 && lat < 5000);
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b0; wr_valid = 1'b0; wr_rs = 1'b0; wr_nib = 1'b0; wr_data = 8'h00;
      #22;
      n_chk++; if (lcd_e !== 1'b0) begin n_err++; $display("FAIL reset_lcd_e got=%b exp=0", lcd_e); end
      n_chk++; if (lcd_rs !== 1'b0) begin n_err++; $display("FAIL reset_lcd_rs got=%b exp=0", lcd_rs); end
      n_chk++; if (lcd_d !== 4'h0) begin n_err++; $display("FAIL reset_lcd_d got=%h exp=0", lcd_d); end
      n_chk++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", wr_ready); end
      n_chk++; if (init_done !== 1'b0) begin n_err++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
      n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got=%b exp=1", busy); end
      #1 rst = 1'b1;
      clear_q();
      n = 0;
      do begin @(posedge clk); #1; n++; end while (wr_ready !== 1'b1 && n < 5000);
`ifdef HD44780_INIT_EN
      begin
         int exp_nib[12] = '{3, 3, 3, 2, 2, 8, 0, 12, 0, 1, 0, 6};
         n_chk++; if (q_d.size() != 12) begin n_err++; $display("FAIL init_pulse_count got=%0d exp=12", q_d.size()); end
         for (int i = 0; i < 12 && i < q_d.size(); i++) begin
            n_chk++; if (q_d[i] != exp_nib[i] || q_rs[i] != 0) begin
               n_err++; $display("FAIL init_nibble[%0d] got=%h rs=%0d exp=%h rs=0", i, q_d[i], q_rs[i], exp_nib[i]);
            end
         end
         if (q_d.size() == 12) begin
            n_chk++; if (q_rise[10] - q_fall[9] < TC) begin
               n_err++; $display("FAIL init_clear_gap got=%0d exp>=%0d", q_rise[10] - q_fall[9], TC);
            end
            n_chk++; if (q_fall[11] > cyc) begin
               n_err++; $display("FAIL init_ready_early got=%0d exp>=%0d", cyc, q_fall[11]);
            end
         end
         n_chk++; if (n <= TP + 12 * PH) begin n_err++; $display("FAIL init_ready_time got=%0d exp>%0d", n, TP + 12 * PH); end
      end
`else
      n_chk++; if (n != TP) begin n_err++; $display("FAIL pwrup_ready_time got=%0d exp=%0d", n, TP); end
      n_chk++; if (q_d.size() != 0) begin n_err++; $display("FAIL pwrup_e_quiet got=%0d exp=0", q_d.size()); end
`endif
      n_chk++; if (init_done !== 1'b1) begin n_err++; $display("FAIL init_done got=%b exp=1", init_done); end
      n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b exp=0", busy); end
   endtask

   // Expected behaviour derived purely from the write's rs/nib/data
   task automatic check_write(input string tag, input logic rs, input logic nib, input logic [7:0] d);
      int lat, exp_lat, wt;
      logic drop_ok;
      int exp_d[$];
      exp_d.push_back(int'(d[7:4]));
      if (!nib) exp_d.push_back(int'(d[3:0]));
      wt = (!rs && d >= 8'h01 && d <= 8'h03) ? TC : TX;
      exp_lat = exp_d.size() * PH + wt;
      do_write(rs, nib, d, lat, drop_ok);
      n_chk++; if (!drop_ok) begin n_err++; $display("FAIL %s ready_drop got=%b exp=0", tag, wr_ready); end
      n_chk++; if (lat != exp_lat) begin n_err++; $display("FAIL %s latency got=%0d exp=%0d", tag, lat, exp_lat); end
      n_chk++; if (q_d.size() != exp_d.size()) begin
         n_err++; $display("FAIL %s pulse_count got=%0d exp=%0d", tag, q_d.size(), exp_d.size());
      end
      for (int i = 0; i < exp_d.size() && i < q_d.size() && i < q_w.size(); i++) begin
         n_chk++; if (q_d[i] != exp_d[i] || q_rs[i] != int'(rs) || q_w[i] != TE) begin
            n_err++;
            $display("FAIL %s pulse[%0d] got d=%h rs=%0d w=%0d exp d=%h rs=%0d w=%0d",
                     tag, i, q_d[i], q_rs[i], q_w[i], exp_d[i], rs, TE);
         end
      end
   endtask

   task automatic test_directed();
      check_write("data_41", 1'b1, 1'b0, 8'h41);
      check_write("clear_01", 1'b0, 1'b0, 8'h01);
      check_write("ddram_80", 1'b0, 1'b0, 8'h80);
      check_write("nib_30", 1'b0, 1'b1, 8'h30);
      check_write("home_02", 1'b0, 1'b0, 8'h02);
      check_write("data_03", 1'b1, 1'b0, 8'h03);
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic rs, nib;
      for (int k = 0; k < 24; k++) begin
         d   = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(1, 3));
         rs  = 1'($urandom_range(0, 1));
         nib = 1'($urandom_range(0, 1));
         check_write($sformatf("rand%0d", k), rs, nib, d);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      n = 0;
      while (wr_ready !== 1'b1 && n < 5000) begin @(posedge clk); #1; n++; end
      clear_q();
      wr_rs = 1'b0; wr_nib = 1'b1; wr_data = 8'h30; wr_valid = 1'b1;
      @(posedge clk); #1;
      wr_rs = 1'b1; wr_nib = 1'b0; wr_data = 8'h41;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (wr_ready !== 1'b1 && n < 5000);
      n_chk++; if (n != PH + TX) begin n_err++; $display("FAIL b2b_first_latency got=%0d exp=%0d", n, PH + TX); end
      @(posedge clk); #1;
      n_chk++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_accept got=%b exp=0", wr_ready); end
      wr_valid = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (wr_ready !== 1'b1 && n < 5000);
      n_chk++; if (n != 2 * PH + TX) begin n_err++; $display("FAIL b2b_second_latency got=%0d exp=%0d", n, 2 * PH + TX); end
      n_chk++; if (q_d.size() != 3 || q_d[0] != 3 || q_d[1] != 4 || q_d[2] != 1) begin
         n_err++; $display("FAIL b2b_nibbles got_count=%0d exp=3 (3,4,1)", q_d.size());
      end
   endtask

   task automatic test_reset_mid();
      int n;
      n = 0;
      while (wr_ready !== 1'b1 && n < 5000) begin @(posedge clk); #1; n++; end
      wr_rs = 1'b1; wr_nib = 1'b0; wr_data = 8'h5A; wr_valid = 1'b1;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      n = 0;
      while (lcd_e !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      n_chk++; if (lcd_e !== 1'b1) begin n_err++; $display("FAIL mid_e_seen got=%b exp=1", lcd_e); end
      #2 rst = 1'b0;
      #1;
      n_chk++; if (lcd_e !== 1'b0) begin n_err++; $display("FAIL mid_rst_e got=%b exp=0", lcd_e); end
      n_chk++; if (wr_ready !== 1'b0 || init_done !== 1'b0) begin
         n_err++; $display("FAIL mid_rst_flags got ready=%b init_done=%b exp 0 0", wr_ready, init_done);
      end
      n_chk++; if (busy !== 1'b1 || lcd_d !== 4'h0 || lcd_rs !== 1'b0) begin
         n_err++; $display("FAIL mid_rst_bus got busy=%b d=%h rs=%b exp 1 0 0", busy, lcd_d, lcd_rs);
      end
      rst = 1'b1;
      @(negedge clk);
      clear_q();
      @(posedge clk); #1;
      n = 1;
      while (wr_ready !== 1'b1 && n < 5000) begin @(posedge clk); #1; n++; end
`ifdef HD44780_INIT_EN
      n_chk++; if (n <= TP) begin n_err++; $display("FAIL mid_pwrup_restart got=%0d exp>%0d", n, TP); end
`else
      n_chk++; if (n != TP) begin n_err++; $display("FAIL mid_pwrup_restart got=%0d exp=%0d", n, TP); end
      n_chk++; if (q_d.size() != 0) begin n_err++; $display("FAIL mid_pwrup_quiet got=%0d exp=0", q_d.size()); end
`endif
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
